// File: rtl/uart_rx_if.sv
// Byte handshake between uart_rx (master) and its consumer (slave).
// A byte moves on every rising clk edge where rx_valid && rx_ready; rx_data is held stable while rx_valid=1.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register, framing and overrun reporting.
// Optional macro UART_RX_PARITY_EN switches to 8E1 and adds the parity_err output.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  bus,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_t;

  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  state_t        state, state_next;
  logic          rx_q1, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          deliver;
  logic          cnt_zero;
  logic          load_half, load_full, sample_data, stop_ok, stop_ferr;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          sample_par, stop_perr;
`endif

  assign cnt_zero  = (cnt == '0);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Synchronizer resets high so a reset release never looks like a start edge on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_half   = 1'b0;
    load_full   = 1'b0;
    sample_data = 1'b0;
    stop_ok     = 1'b0;
    stop_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
    stop_perr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          load_half  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            load_full  = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_zero) begin
          sample_data = 1'b1;
          load_full   = 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          sample_par = 1'b1;
          load_full  = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
        if (cnt_zero) begin
          if (!rx_s) begin
            stop_ferr  = 1'b1;
            state_next = WAIT_IDLE;
          end else begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift, par_bit}) stop_perr = 1'b1;
            else                   stop_ok   = 1'b1;
`else
            stop_ok = 1'b1;
`endif
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
    end else begin
      if (load_half)      cnt <= HALF_LOAD;
      else if (load_full) cnt <= FULL_LOAD;
      else if (!cnt_zero) cnt <= cnt - 1'b1;

      if (state == IDLE)    idx <= 3'd0;
      else if (sample_data) idx <= idx + 3'd1;

      if (sample_data) shift[idx] <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (sample_par) par_bit <= rx_s;
      parity_err <= stop_perr;
    end
  end
`endif

  // Holding register: a delivery lands one clock after the mid-stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deliver      <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
    end else begin
      deliver   <= stop_ok;
      frame_err <= stop_ferr;
      overrun   <= deliver && bus.rx_valid && !bus.rx_ready;
      if (deliver && (!bus.rx_valid || bus.rx_ready)) begin
        bus.rx_data  <= shift;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule
